ahb_cmd_master: RTL and testbench
=================================

// Module: ahb_cmd_master
// PURPOSE
//  AHB-Lite bus master (initiator) that turns a valid/ready command stream into single
//  NONSEQ transfers on the system bus, and returns one response per command, in order.
//  Sits beside the Cortex-M0 as a second initiator (behind an arbiter) or drives a
//  slave subsystem directly. Address phase of the next transfer overlaps the data phase
//  of the current one.
// PARAMETERS
//  HPROT_VAL   4'b0011  constant driven on HPROT (data access, privileged)
//  ERR_CANCEL  1        1: on an ERROR response, drive IDLE in the second error cycle, then
//                       re-issue the pending transfer; 0: pending transfer continues unchanged
// PORTS
//  HCLK       in   1   bus clock
//  HRESETn    in   1   asynchronous reset, active low
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   command accepted on an edge where cmd_valid & cmd_ready
//  cmd_write  in   1   1 = write, 0 = read
//  cmd_size   in   2   0 = byte, 1 = halfword, 2 = word; 3 is treated as word
//  cmd_addr   in   32  byte address
//  cmd_wdata  in   32  write data, right-justified
//  rsp_valid  out  1   one-cycle response pulse
//  rsp_write  out  1   response belongs to a write
//  rsp_err    out  1   slave returned ERROR
//  rsp_rdata  out  32  read data, right-justified and zero-extended (0 for writes)
//  busy       out  1   address or data phase outstanding
//  HADDR      out  32  AHB address
//  HTRANS     out  2   AHB transfer type; only IDLE (00) or NONSEQ (10) is driven
//  HWRITE     out  1   AHB write
//  HSIZE      out  3   {1'b0, size}
//  HBURST     out  3   tied to 3'b000 (SINGLE)
//  HPROT      out  4   HPROT_VAL
//  HMASTLOCK  out  1   tied to 0
//  HWDATA     out  32  write data, valid during the data phase
//  HRDATA     in   32  read data
//  HREADY     in   1   bus ready
//  HRESP      in   1   bus error response
// BEHAVIOUR
//  - State: address-phase register (ap_*), data-phase register (dp_*), err_hold flag.
//  - Reset values (async, immediate):
//    - ap_valid = dp_valid = err_hold = 0.
//    - HTRANS = IDLE; HADDR, HWRITE, HSIZE and HWDATA all 0.
//    - rsp_valid = rsp_write = rsp_err = 0; rsp_rdata = 0; busy = 0.
//  - HTRANS = (ap_valid & !err_hold) ? NONSEQ : IDLE.
//  - HADDR, HWRITE and HSIZE come from the ap register and are held while HREADY = 0.
//  - HADDR is aligned: halfword forces bit 0 to 0; word forces bits [1:0] to 0.
//  - cmd_ready = !ap_valid | (HREADY & !err_hold). It is combinational and 1 after reset.
//  - Accept edge: the ap register loads the command, so the address phase starts in the
//    next cycle.
//  - Address phase completes on an edge with ap_valid & HREADY & !err_hold. At that edge:
//    - dp loads write, size and addr[1:0];
//    - dp loads wdata with lane replication (byte -> x4, halfword -> x2);
//    - ap_valid clears unless a new command is accepted on the same edge.
//  - HWDATA is driven from the dp register for the whole data phase.
//  - Data phase completes on an edge with dp_valid & HREADY. In the next cycle:
//    - rsp_valid = 1, rsp_err = HRESP;
//    - rsp_rdata = HRDATA lane selected by size/addr[1:0], zero-extended.
//  - Latency, zero-wait bus: rsp_valid is high 2 cycles after the accept edge.
//    Each data-phase wait state adds 1. Back-to-back throughput: 1 command per cycle.
//  - Error handling (ERR_CANCEL = 1):
//    - An edge with dp_valid & HRESP & !HREADY (first error cycle) sets err_hold.
//    - In the second error cycle HTRANS = IDLE, so the pending ap transfer is not taken.
//    - err_hold clears on the next HREADY edge; the pending ap is re-driven as NONSEQ.
//    - The erroring command gets rsp_err = 1.
//  - ERR_CANCEL = 0: err_hold is never set.
//  - No responses are produced without a completed bus transfer, and response order
//    equals command order.
//  - Reset mid-operation: in-flight commands are dropped silently and no rsp_valid is
//    issued. The bus returns to IDLE immediately.
// TESTING
//  - Word write 0x2000_0004 / 0xCAFEF00D, HREADY = 1 ->
//    HTRANS = NONSEQ for 1 cycle, HWDATA = 0xCAFEF00D the next cycle;
//    rsp_valid 2 cycles after accept; rsp_err = 0.
//  - 3 back-to-back word reads 0x0, 0x4, 0x8, slave returns 0x11, 0x22, 0x33 ->
//    NONSEQ in 3 consecutive cycles; rsp_rdata 0x11, 0x22, 0x33 in consecutive cycles.
//  - HREADY = 0 for 3 cycles in the data phase, second command pending ->
//    HADDR/HTRANS held stable; cmd_ready = 0; rsp delayed by exactly 3 cycles.
//  - Byte read at 0x5000_0003 with HRDATA = 0x11223344 -> rsp_rdata = 0x00000011.
//    Byte write 0xA5 -> HSIZE = 000, HWDATA = 0xA5A5A5A5.
//  - HRESP = 1 / HREADY = 0, then HRESP = 1 / HREADY = 1, next command pending ->
//    HTRANS = IDLE in the second cycle; rsp_err = 1; pending command re-issued as
//    NONSEQ and completes with rsp_err = 0.
//  - HRESETn low during a wait state ->
//    HTRANS = IDLE, rsp_valid = 0 and busy = 0 with no clock edge; no response ever
//    issued for the dropped commands.

Source files
------------

// File: rtl/ahb_cmd_master.sv
`timescale 1ns/1ps
// AHB-Lite initiator: turns a valid/ready command stream into single NONSEQ
// transfers and returns one in-order response per command. The address phase
// of the next transfer overlaps the data phase of the current one.
module ahb_cmd_master #(
  parameter logic [3:0]  HPROT_VAL  = 4'b0011,
  parameter int unsigned ERR_CANCEL = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] SZ_BYTE      = 2'd0;
  localparam logic [1:0] SZ_HALF      = 2'd1;
  localparam logic [1:0] SZ_WORD      = 2'd2;

  // Address-phase register
  logic        ap_valid_q, ap_valid_d;
  logic        ap_write_q, ap_write_d;
  logic [1:0]  ap_size_q,  ap_size_d;
  logic [31:0] ap_addr_q,  ap_addr_d;
  logic [31:0] ap_wdata_q, ap_wdata_d;

  // Data-phase register
  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q, dp_write_d;
  logic [1:0]  dp_size_q,  dp_size_d;
  logic [1:0]  dp_lane_q,  dp_lane_d;
  logic [31:0] dp_wdata_q, dp_wdata_d;

  logic        err_hold_q, err_hold_d;

  // Response register
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic        rsp_err_q,   rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        accept;
  logic        ap_done;
  logic        dp_done;
  logic [1:0]  cmd_size_n;
  logic [31:0] cmd_addr_al;
  logic [31:0] wdata_rep;
  logic [31:0] rd_lane;

  assign cmd_ready = !ap_valid_q | (HREADY & !err_hold_q);
  assign accept    = cmd_valid & cmd_ready;
  assign ap_done   = ap_valid_q & HREADY & !err_hold_q;
  assign dp_done   = dp_valid_q & HREADY;

  // Normalise the incoming command: size 3 behaves as word, address aligned to size
  always_comb begin
    cmd_size_n  = (cmd_size == 2'd3) ? SZ_WORD : cmd_size;
    cmd_addr_al = cmd_addr;
    case (cmd_size_n)
      SZ_HALF: cmd_addr_al[0]   = 1'b0;
      SZ_WORD: cmd_addr_al[1:0] = 2'b00;
      default: ;
    endcase
  end

  // Replicate write data across byte lanes so any slave lane sees it
  always_comb begin
    case (ap_size_q)
      SZ_BYTE: wdata_rep = {4{ap_wdata_q[7:0]}};
      SZ_HALF: wdata_rep = {2{ap_wdata_q[15:0]}};
      default: wdata_rep = ap_wdata_q;
    endcase
  end

  // Pick the active read lane and zero-extend it
  always_comb begin
    rd_lane = '0;
    case (dp_size_q)
      SZ_BYTE: begin
        case (dp_lane_q)
          2'd0:    rd_lane = {24'b0, HRDATA[7:0]};
          2'd1:    rd_lane = {24'b0, HRDATA[15:8]};
          2'd2:    rd_lane = {24'b0, HRDATA[23:16]};
          default: rd_lane = {24'b0, HRDATA[31:24]};
        endcase
      end
      SZ_HALF: rd_lane = dp_lane_q[1] ? {16'b0, HRDATA[31:16]} : {16'b0, HRDATA[15:0]};
      default: rd_lane = HRDATA;
    endcase
  end

  // Next-state for the address-phase register; a same-edge accept refills it
  always_comb begin
    ap_valid_d = ap_valid_q;
    ap_write_d = ap_write_q;
    ap_size_d  = ap_size_q;
    ap_addr_d  = ap_addr_q;
    ap_wdata_d = ap_wdata_q;
    if (ap_done) ap_valid_d = 1'b0;
    if (accept) begin
      ap_valid_d = 1'b1;
      ap_write_d = cmd_write;
      ap_size_d  = cmd_size_n;
      ap_addr_d  = cmd_addr_al;
      ap_wdata_d = cmd_wdata;
    end
  end

  // Next-state for the data-phase register; a completing address phase refills it
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_size_d  = dp_size_q;
    dp_lane_d  = dp_lane_q;
    dp_wdata_d = dp_wdata_q;
    if (dp_done) dp_valid_d = 1'b0;
    if (ap_done) begin
      dp_valid_d = 1'b1;
      dp_write_d = ap_write_q;
      dp_size_d  = ap_size_q;
      dp_lane_d  = ap_addr_q[1:0];
      dp_wdata_d = wdata_rep;
    end
  end

  // Error hold: set in the first ERROR cycle so the pending transfer goes IDLE
  // in the second, then released on the completing edge so it is re-issued
  always_comb begin
    err_hold_d = 1'b0;
    if (ERR_CANCEL != 0) begin
      if (dp_valid_q & HRESP & !HREADY) err_hold_d = 1'b1;
      else if (HREADY)                  err_hold_d = 1'b0;
      else                              err_hold_d = err_hold_q;
    end
  end

  // Response capture on data-phase completion
  always_comb begin
    rsp_valid_d = dp_done;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (dp_done) begin
      rsp_write_d = dp_write_q;
      rsp_err_d   = HRESP;
      rsp_rdata_d = dp_write_q ? '0 : rd_lane;
    end
  end

  // State registers; reset drops all in-flight work
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid_q  <= 1'b0;
      ap_write_q  <= 1'b0;
      ap_size_q   <= '0;
      ap_addr_q   <= '0;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_size_q   <= '0;
      dp_lane_q   <= '0;
      dp_wdata_q  <= '0;
      err_hold_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      ap_valid_q  <= ap_valid_d;
      ap_write_q  <= ap_write_d;
      ap_size_q   <= ap_size_d;
      ap_addr_q   <= ap_addr_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_size_q   <= dp_size_d;
      dp_lane_q   <= dp_lane_d;
      dp_wdata_q  <= dp_wdata_d;
      err_hold_q  <= err_hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign HTRANS    = (ap_valid_q & !err_hold_q) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR     = ap_addr_q;
  assign HWRITE    = ap_write_q;
  assign HSIZE     = {1'b0, ap_size_q};
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = dp_wdata_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = ap_valid_q | dp_valid_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
`timescale 1ns/1ps
// Bench for ahb_cmd_master: a slave model answers each data phase from the
// command record; address phases, write data and responses are checked against
// queues filled when commands are accepted.
module tb_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_write, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  ahb_cmd_master #(.HPROT_VAL(4'b0011), .ERR_CANCEL(1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    int          waits;
    logic        err;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
    logic [31:0] exp_hwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc_cyc;
  } rsp_t;

  vec_t addr_q[$];
  rsp_t rsp_q[$];
  vec_t dp_rec;
  bit   dp_vld;
  int   dp_cyc;
  int   cyc_n;
  bit   acc_flag;
  vec_t cur;
  int   cur_lat;
  int   n_checks;
  int   n_errors;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event/timeout expected none (cycle %0d)", name, cyc_n);
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] bus, input int waits,
                              input logic err, input logic [31:0] haddr, input logic [2:0] hsize,
                              input logic [31:0] hwdata, input logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.bus_rdata = bus;
    v.waits = waits; v.err = err; v.exp_haddr = haddr; v.exp_hsize = hsize;
    v.exp_hwdata = hwdata; v.exp_rdata = rdata;
    return v;
  endfunction

  // Slave response for the cycle just starting, from the current data-phase record
  task automatic drive_slave();
    if (!dp_vld || !HRESETn) begin
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hDEAD_BEEF;
    end else begin
      HRDATA = dp_rec.bus_rdata;
      if (dp_rec.err) begin
        HRESP  = 1'b1;
        HREADY = (dp_cyc != 0);
      end else begin
        HRESP  = 1'b0;
        HREADY = (dp_cyc >= dp_rec.waits);
      end
    end
  endtask

  // One clock: check at the falling edge, then drive the slave after the rising edge
  task automatic cycle();
    rsp_t r;
    vec_t v;
    @(negedge HCLK);
    cyc_n++;
    acc_flag = 1'b0;
    if (HRESETn) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) fail_evt("unexpected_rsp");
        else begin
          r = rsp_q.pop_front();
          chk("rsp_write", 32'(rsp_write), 32'(r.wr));
          chk("rsp_err",   32'(rsp_err),   32'(r.err));
          chk("rsp_rdata", rsp_rdata, r.rdata);
          if (r.lat >= 0) chk("rsp_latency", 32'(cyc_n - r.acc_cyc - 1), 32'(r.lat));
        end
      end
      chk("busy", 32'(busy), 32'(addr_q.size() != 0 || dp_vld));
      if (dp_vld && dp_rec.err && dp_cyc == 1) begin
        chk("htrans_err2", 32'(HTRANS), 32'h0);
        if (addr_q.size() != 0) chk("ready_err2", 32'(cmd_ready), 32'h0);
      end
      if (dp_vld) begin
        if (dp_rec.wr) chk("hwdata", HWDATA, dp_rec.exp_hwdata);
        if (HREADY) dp_vld = 1'b0;
        else dp_cyc++;
      end
      if (HTRANS == 2'b10) begin
        if (addr_q.size() == 0) fail_evt("spurious_nonseq");
        else begin
          v = addr_q[0];
          chk("haddr",  HADDR, v.exp_haddr);
          chk("hsize",  32'(HSIZE), 32'(v.exp_hsize));
          chk("hwrite", 32'(HWRITE), 32'(v.wr));
          if (!HREADY) chk("ready_stall", 32'(cmd_ready), 32'h0);
          else begin
            v = addr_q.pop_front();
            dp_rec = v; dp_vld = 1'b1; dp_cyc = 0;
          end
        end
      end else begin
        chk("htrans_idle", 32'(HTRANS), 32'h0);
      end
      if (cmd_valid && cmd_ready) begin
        acc_flag = 1'b1;
        addr_q.push_back(cur);
        r.wr = cur.wr; r.err = cur.err; r.rdata = cur.exp_rdata;
        r.lat = cur_lat; r.acc_cyc = cyc_n;
        rsp_q.push_back(r);
      end
    end
    @(posedge HCLK);
    #1;
    drive_slave();
  endtask

  task automatic issue(input vec_t v, input int lat);
    cur = v; cur_lat = lat;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_size = v.size;
    cmd_addr = v.addr; cmd_wdata = v.wdata;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (acc_flag) break;
    end
    if (!acc_flag) fail_evt("accept_timeout");
    cmd_valid = 1'b0;
    cmd_addr  = $urandom();
    cmd_wdata = $urandom();
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (rsp_q.size() != 0 || addr_q.size() != 0 || dp_vld); k++) cycle();
    if (rsp_q.size() != 0 || addr_q.size() != 0 || dp_vld) fail_evt("drain_timeout");
  endtask

  initial begin
    int start;
    n_checks = 0; n_errors = 0; cyc_n = 0; dp_vld = 1'b0; dp_cyc = 0;
    HRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0; cmd_addr = '0; cmd_wdata = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;

    //          wr    sz    addr           wdata          bus           w  err  haddr          hsz   hwdata         rdata
    tbl[0]  = mk(1'b1, 2'd2, 32'h2000_0004, 32'hCAFE_F00D, 32'h0,        0, 1'b0, 32'h2000_0004, 3'd2, 32'hCAFE_F00D, 32'h0);
    tbl[1]  = mk(1'b0, 2'd0, 32'h5000_0003, 32'h0,         32'h1122_3344, 0, 1'b0, 32'h5000_0003, 3'd0, 32'h0,         32'h0000_0011);
    tbl[2]  = mk(1'b1, 2'd0, 32'h0000_0010, 32'h0000_00A5, 32'h0,        1, 1'b0, 32'h0000_0010, 3'd0, 32'hA5A5_A5A5, 32'h0);
    tbl[3]  = mk(1'b0, 2'd1, 32'h0000_0101, 32'h0,         32'hAABB_CCDD, 0, 1'b0, 32'h0000_0100, 3'd1, 32'h0,         32'h0000_CCDD);
    tbl[4]  = mk(1'b0, 2'd1, 32'h0000_1002, 32'h0,         32'hAABB_CCDD, 2, 1'b0, 32'h0000_1002, 3'd1, 32'h0,         32'h0000_AABB);
    tbl[5]  = mk(1'b1, 2'd1, 32'h0000_3003, 32'h1234_5678, 32'h0,        0, 1'b0, 32'h0000_3002, 3'd1, 32'h5678_5678, 32'h0);
    tbl[6]  = mk(1'b0, 2'd0, 32'h0000_0041, 32'h0,         32'hAABB_CCDD, 0, 1'b0, 32'h0000_0041, 3'd0, 32'h0,         32'h0000_00CC);
    tbl[7]  = mk(1'b0, 2'd0, 32'h0000_0042, 32'h0,         32'hAABB_CCDD, 2, 1'b0, 32'h0000_0042, 3'd0, 32'h0,         32'h0000_00BB);
    tbl[8]  = mk(1'b0, 2'd3, 32'h0000_0007, 32'h0,         32'h8765_4321, 1, 1'b0, 32'h0000_0004, 3'd2, 32'h0,         32'h8765_4321);
    tbl[9]  = mk(1'b1, 2'd3, 32'h0000_000B, 32'h0BAD_F00D, 32'h0,        0, 1'b0, 32'h0000_0008, 3'd2, 32'h0BAD_F00D, 32'h0);
    tbl[10] = mk(1'b0, 2'd2, 32'h0000_0060, 32'h0,         32'h0,        0, 1'b1, 32'h0000_0060, 3'd2, 32'h0,         32'h0);
    tbl[11] = mk(1'b1, 2'd0, 32'h0000_0044, 32'h1234_56C3, 32'h0,        0, 1'b1, 32'h0000_0044, 3'd0, 32'hC3C3_C3C3, 32'h0);
    tbl[12] = mk(1'b0, 2'd0, 32'h0000_0040, 32'h0,         32'hAABB_CCDD, 0, 1'b0, 32'h0000_0040, 3'd0, 32'h0,         32'h0000_00DD);

    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_htrans",    32'(HTRANS), 32'h0);
    chk("rst_haddr",     HADDR, 32'h0);
    chk("rst_hwrite",    32'(HWRITE), 32'h0);
    chk("rst_hsize",     32'(HSIZE), 32'h0);
    chk("rst_hwdata",    HWDATA, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_write", 32'(rsp_write), 32'h0);
    chk("rst_rsp_err",   32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_busy",      32'(busy), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("hburst",        32'(HBURST), 32'h0);
    chk("hprot",         32'(HPROT), 32'h3);
    chk("hmastlock",     32'(HMASTLOCK), 32'h0);
    HRESETn = 1'b1;
    drive_slave();

    // Isolated commands: latency is 2 plus wait states (an ERROR adds one)
    for (int i = 0; i < 13; i++) begin
      issue(tbl[i], 2 + tbl[i].waits + (tbl[i].err ? 1 : 0));
      drain();
    end

    // Three back-to-back word reads accepted in consecutive cycles
    start = cyc_n;
    issue(mk(1'b0, 2'd2, 32'h0, 32'h0, 32'h11, 0, 1'b0, 32'h0, 3'd2, 32'h0, 32'h11), 2);
    issue(mk(1'b0, 2'd2, 32'h4, 32'h0, 32'h22, 0, 1'b0, 32'h4, 3'd2, 32'h0, 32'h22), 2);
    issue(mk(1'b0, 2'd2, 32'h8, 32'h0, 32'h33, 0, 1'b0, 32'h8, 3'd2, 32'h0, 32'h33), 2);
    chk("b2b_accept_cycles", 32'(cyc_n - start), 32'd3);
    drain();

    // Three data-phase wait states with a second command pending
    issue(mk(1'b0, 2'd2, 32'h100, 32'h0, 32'hA1A1_0001, 3, 1'b0, 32'h100, 3'd2, 32'h0, 32'hA1A1_0001), 5);
    issue(mk(1'b1, 2'd2, 32'h104, 32'h7777_8888, 32'h0, 0, 1'b0, 32'h104, 3'd2, 32'h7777_8888, 32'h0), 5);
    drain();

    // ERROR response with a pending command: IDLE cycle, then re-issue
    issue(mk(1'b0, 2'd2, 32'h200, 32'h0, 32'h0, 0, 1'b1, 32'h200, 3'd2, 32'h0, 32'h0), 3);
    issue(mk(1'b0, 2'd2, 32'h204, 32'h0, 32'h55, 0, 1'b0, 32'h204, 3'd2, 32'h0, 32'h55), 4);
    drain();

    // Reset in the middle of a wait state drops everything in flight
    issue(mk(1'b0, 2'd2, 32'h300, 32'h0, 32'h1, 20, 1'b0, 32'h300, 3'd2, 32'h0, 32'h1), -1);
    issue(mk(1'b0, 2'd2, 32'h304, 32'h0, 32'h2, 0, 1'b0, 32'h304, 3'd2, 32'h0, 32'h2), -1);
    cycle();
    cycle();
    chk("pre_rst_busy", 32'(busy), 32'h1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("midrst_htrans",    32'(HTRANS), 32'h0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_busy",      32'(busy), 32'h0);
    addr_q.delete();
    rsp_q.delete();
    dp_vld = 1'b0;
    cycle();
    cycle();
    HRESETn = 1'b1;
    drive_slave();
    repeat (8) cycle();

    // Recovery after reset
    issue(mk(1'b1, 2'd2, 32'h400, 32'h600D_CAFE, 32'h0, 0, 1'b0, 32'h400, 3'd2, 32'h600D_CAFE, 32'h0), 2);
    drain();
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1);
  end

endmodule
